// File: rtl/ula_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide over WIDTH cycles.
module ula_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       OP,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             Zero_flag,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_nx;
    logic [SW-1:0]    cnt;
    logic             is_div, neg_q, neg_r;
    logic [WIDTH-1:0] acc_hi, acc_lo, opb;

    logic             is_mul_op, is_div_op, signed_op, div_zero, multi;
    logic [WIDTH-1:0] a_mag, b_mag, alu_res;
    logic [SW-1:0]    shamt;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    always_comb begin
        is_mul_op = (OP == 4'b1001) || (OP == 4'b1010);
        is_div_op = (OP == 4'b1101) || (OP == 4'b1110);
        signed_op = (OP == 4'b1001) || (OP == 4'b1101);
        div_zero  = is_div_op && (In2 == '0);
        multi     = is_mul_op || (is_div_op && !div_zero);
        a_mag     = (signed_op && In1[WIDTH-1]) ? -In1 : In1;
        b_mag     = (signed_op && In2[WIDTH-1]) ? -In2 : In2;
        shamt     = In2[SW-1:0];
    end

    always_comb begin
        alu_res = '0;
        case (OP)
            4'b0000: alu_res = In1 & In2;
            4'b0001: alu_res = In1 | In2;
            4'b0010: alu_res = In1 + In2;
            4'b0011: alu_res = In1 << shamt;
            4'b0100: alu_res = In1 >> shamt;
            4'b0101: alu_res = $signed(In1) >>> shamt;
            4'b0110: alu_res = In1 - In2;
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(In1) < $signed(In2))};
            4'b1000: alu_res = In1 - In2;
            4'b1011: alu_res = In1 ^ In2;
            4'b1100: alu_res = ~(In1 | In2);
            4'b1111: alu_res = {{(WIDTH-1){1'b0}}, (In1 < In2)};
            default: alu_res = '0;
        endcase
    end

    // acc_lo holds the multiplier (shifted out LSB-first) or the dividend
    // (shifted out MSB-first into the partial remainder in acc_hi).
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opb};
        div_diff  = div_shift[WIDTH-1:0] - opb;
        prod      = {acc_hi, acc_lo};
        prod_fix  = neg_q ? -prod : prod;
        quo_fix   = neg_q ? -acc_lo : acc_lo;
        rem_fix   = neg_r ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        case (state)
            IDLE: if (start && multi) state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) state_nx = FIX;
            end
            FIX: begin
                busy     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opb         <= '0;
            result      <= '0;
            hi          <= '0;
            lo          <= '0;
            Zero_flag   <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (multi) begin
                        cnt    <= SW'(WIDTH - 1);
                        is_div <= is_div_op;
                        neg_q  <= signed_op && (In1[WIDTH-1] ^ In2[WIDTH-1]);
                        neg_r  <= signed_op && In1[WIDTH-1];
                        acc_hi <= '0;
                        acc_lo <= a_mag;
                        opb    <= b_mag;
                    end else if (div_zero) begin
                        result      <= '1;
                        lo          <= '1;
                        hi          <= In1;
                        Zero_flag   <= 1'b0;
                        done        <= 1'b1;
                        div_by_zero <= 1'b1;
                    end else begin
                        result    <= alu_res;
                        Zero_flag <= (OP == 4'b1000) ? (alu_res != '0) : (alu_res == '0);
                        done      <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (is_div) begin
                        acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (is_div) begin
                        lo        <= quo_fix;
                        hi        <= rem_fix;
                        result    <= quo_fix;
                        Zero_flag <= (quo_fix == '0);
                    end else begin
                        hi        <= prod_fix[2*WIDTH-1:WIDTH];
                        lo        <= prod_fix[WIDTH-1:0];
                        result    <= prod_fix[WIDTH-1:0];
                        Zero_flag <= (prod_fix[WIDTH-1:0] == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_mc.sv
// Self-checking bench for ula_mc: directed vectors plus randomized ops
// against an arithmetic reference model.
module tb_ula_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [3:0]   OP;
    logic [W-1:0] In1, In2;
    logic [W-1:0] result, hi, lo;
    logic         Zero_flag, busy, done, div_by_zero;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] m_res, m_hi, m_lo;
    logic         m_zf, m_dbz, m_multi;

    ula_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .OP(OP), .In1(In1), .In2(In2),
        .result(result), .hi(hi), .lo(lo), .Zero_flag(Zero_flag),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference model: plain 64-bit arithmetic on the operation definitions.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint              sa, sb, sp, sq, sr;
        logic [63:0]         ua, ub, up;
        logic signed [W-1:0] a_s;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        a_s = a;
        m_dbz = 1'b0;
        m_multi = 1'b0;
        case (op)
            4'd0:  m_res = a & b;
            4'd1:  m_res = a | b;
            4'd2:  m_res = a + b;
            4'd3:  m_res = a << b[4:0];
            4'd4:  m_res = a >> b[4:0];
            4'd5:  m_res = a_s >>> b[4:0];
            4'd6:  m_res = a - b;
            4'd7:  m_res = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  m_res = a - b;
            4'd11: m_res = a ^ b;
            4'd12: m_res = ~(a | b);
            4'd15: m_res = (a < b) ? 32'd1 : 32'd0;
            4'd9, 4'd10: begin
                if (op == 4'd9) begin
                    sp = sa * sb;
                    up = sp;
                end else begin
                    up = ua * ub;
                end
                m_hi = up[63:32];
                m_lo = up[31:0];
                m_res = m_lo;
                m_multi = 1'b1;
            end
            default: begin
                if (b == 0) begin
                    m_dbz = 1'b1;
                    m_lo = '1;
                    m_hi = a;
                    m_res = '1;
                end else begin
                    if (op == 4'd13) begin
                        sq = sa / sb;
                        sr = sa % sb;
                        up = sq;
                        ua = sr;
                    end else begin
                        up = ua / ub;
                        ua = ua % ub;
                    end
                    m_lo = up[31:0];
                    m_hi = ua[31:0];
                    m_res = m_lo;
                    m_multi = 1'b1;
                end
            end
        endcase
        m_zf = (op == 4'd8) ? (m_res != 0) : (m_res == 0);
    endtask

    // Issues one op and waits (bounded) for done; optionally scrambles inputs while busy.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit disturb, output int lat, output int bcnt);
        @(negedge clk);
        OP = op; In1 = a; In2 = b; start = 1'b1;
        model(op, a, b);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            if (disturb) begin
                OP = 4'($urandom);
                In1 = $urandom;
                In2 = $urandom;
                start = (lat % 5 == 2);
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({result, hi, lo, Zero_flag, busy, done, div_by_zero} !== {(3*W+4){1'b0}}) begin
            bad++;
            $display("FAIL reset_async: got res=%h hi=%h lo=%h z=%b busy=%b done=%b dbz=%b, want all 0",
                     result, hi, lo, Zero_flag, busy, done, div_by_zero);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({result, hi, lo, Zero_flag, busy, done, div_by_zero} !== {(3*W+4){1'b0}}) begin
            bad++;
            $display("FAIL reset_release: got res=%h hi=%h lo=%h z=%b busy=%b done=%b, want all 0",
                     result, hi, lo, Zero_flag, busy, done);
        end
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic test_vectors;
        logic [3:0]   v_op  [9] = '{4'd2, 4'd5, 4'd8, 4'd8, 4'd9, 4'd14, 4'd13, 4'd13, 4'd14};
        logic [W-1:0] v_a   [9] = '{32'd5, 32'h80000000, 32'd9, 32'd9, 32'hFFFFFFFD, 32'd100,
                                    32'hFFFFFFF9, 32'h80000000, 32'h1234};
        logic [W-1:0] v_b   [9] = '{32'd7, 32'd4, 32'd9, 32'd3, 32'd7, 32'd7, 32'd2, 32'hFFFFFFFF, 32'd0};
        logic [W-1:0] v_res [9] = '{32'd12, 32'hF8000000, 32'd0, 32'd6, 32'hFFFFFFEB, 32'd14,
                                    32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
        logic         v_zf  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int lat, bcnt, exp_lat, exp_b;
        for (int i = 0; i < 9; i++) begin
            run_op(v_op[i], v_a[i], v_b[i], (i == 4), lat, bcnt);
            exp_lat = m_multi ? W + 2 : 1;
            exp_b   = m_multi ? W + 1 : 0;
            total++;
            if (result !== v_res[i] || Zero_flag !== v_zf[i]) begin
                bad++;
                $display("FAIL vec_const[%0d]: got res=%h z=%b, want res=%h z=%b", i, result, Zero_flag, v_res[i], v_zf[i]);
            end
            total++;
            if ({result, hi, lo, Zero_flag, div_by_zero} !== {m_res, m_hi, m_lo, m_zf, m_dbz}) begin
                bad++;
                $display("FAIL vec_model[%0d]: got res=%h hi=%h lo=%h z=%b dbz=%b, want res=%h hi=%h lo=%h z=%b dbz=%b",
                         i, result, hi, lo, Zero_flag, div_by_zero, m_res, m_hi, m_lo, m_zf, m_dbz);
            end
            total++;
            if (lat !== exp_lat || bcnt !== exp_b || busy !== 1'b0) begin
                bad++;
                $display("FAIL vec_timing[%0d]: got lat=%0d busy_cycles=%0d busy=%b, want lat=%0d busy_cycles=%0d busy=0",
                         i, lat, bcnt, busy, exp_lat, exp_b);
            end
        end
    endtask

    task automatic test_random;
        int lat, bcnt, exp_lat;
        logic [3:0]   op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom);
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0) a = W'($urandom_range(0, 3)) << (W - 2);
            run_op(op, a, b, 1'b0, lat, bcnt);
            exp_lat = m_multi ? W + 2 : 1;
            total++;
            if ({result, hi, lo, Zero_flag, div_by_zero} !== {m_res, m_hi, m_lo, m_zf, m_dbz} || lat !== exp_lat) begin
                bad++;
                $display("FAIL rand[%0d] op=%h a=%h b=%h: got res=%h hi=%h lo=%h z=%b dbz=%b lat=%0d, want res=%h hi=%h lo=%h z=%b dbz=%b lat=%0d",
                         i, op, a, b, result, hi, lo, Zero_flag, div_by_zero, lat,
                         m_res, m_hi, m_lo, m_zf, m_dbz, exp_lat);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int lat, bcnt;
        logic [3:0] ops [3] = '{4'd10, 4'd13, 4'd9};
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], $urandom, $urandom | 32'h1, 1'b1, lat, bcnt);
            total++;
            if ({result, hi, lo, Zero_flag, div_by_zero} !== {m_res, m_hi, m_lo, m_zf, m_dbz} ||
                lat !== W + 2 || bcnt !== W + 1) begin
                bad++;
                $display("FAIL busy_ignore[%0d]: got res=%h hi=%h lo=%h lat=%0d busy_cycles=%0d, want res=%h hi=%h lo=%h lat=%0d busy_cycles=%0d",
                         i, result, hi, lo, lat, bcnt, m_res, m_hi, m_lo, W + 2, W + 1);
            end
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL busy_extra_done[%0d]: got done=%b busy=%b, want done=0 busy=0", i, done, busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] sops [5] = '{4'd0, 4'd2, 4'd6, 4'd11, 4'd15};
        int lat;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            OP = sops[$urandom_range(0, 4)];
            In1 = $urandom;
            In2 = $urandom;
            start = 1'b1;
            model(OP, In1, In2);
            @(negedge clk);
            total++;
            if (done !== 1'b1 || result !== m_res || Zero_flag !== m_zf) begin
                bad++;
                $display("FAIL b2b_single[%0d]: got done=%b res=%h z=%b, want done=1 res=%h z=%b", i, done, result, Zero_flag, m_res, m_zf);
            end
        end
        OP = 4'd9; In1 = $urandom; In2 = $urandom;
        model(OP, In1, In2);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== W + 2 || {hi, lo} !== {m_hi, m_lo}) begin
            bad++;
            $display("FAIL b2b_mult: got lat=%0d hi=%h lo=%h, want lat=%0d hi=%h lo=%h", lat, hi, lo, W + 2, m_hi, m_lo);
        end
        OP = 4'd2; In1 = $urandom; In2 = $urandom; start = 1'b1;
        model(OP, In1, In2);
        @(negedge clk);
        start = 1'b0;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== m_res || {hi, lo} !== {m_hi, m_lo}) begin
            bad++;
            $display("FAIL b2b_after_mult: got done=%b busy=%b res=%h hi=%h lo=%h, want done=1 busy=0 res=%h hi=%h lo=%h",
                     done, busy, result, hi, lo, m_res, m_hi, m_lo);
        end
    endtask

    task automatic test_div_zero;
        int lat, bcnt;
        for (int i = 0; i < 2; i++) begin
            run_op((i == 0) ? 4'd14 : 4'd13, (i == 0) ? 32'h1234 : $urandom, 32'd0, 1'b0, lat, bcnt);
            total++;
            if ({result, hi, lo, div_by_zero, done} !== {m_res, m_hi, m_lo, 1'b1, 1'b1} ||
                lat !== 1 || busy !== 1'b0 || bcnt !== 0) begin
                bad++;
                $display("FAIL div_zero[%0d]: got res=%h hi=%h lo=%h dbz=%b lat=%0d busy=%b, want res=%h hi=%h lo=%h dbz=1 lat=1 busy=0",
                         i, result, hi, lo, div_by_zero, lat, busy, m_res, m_hi, m_lo);
            end
            @(negedge clk);
            total++;
            if (div_by_zero !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL div_zero_after[%0d]: got dbz=%b busy=%b done=%b, want 0 0 0", i, div_by_zero, busy, done);
            end
        end
    endtask

    task automatic test_reset_mid;
        int dones, lat, bcnt;
        @(negedge clk);
        OP = 4'd9; In1 = $urandom | 32'h1; In2 = $urandom | 32'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({result, hi, lo, Zero_flag, busy, done, div_by_zero} !== {(3*W+4){1'b0}}) begin
            bad++;
            $display("FAIL reset_mid: got res=%h hi=%h lo=%h z=%b busy=%b done=%b dbz=%b, want all 0",
                     result, hi, lo, Zero_flag, busy, done, div_by_zero);
        end
        m_hi = '0;
        m_lo = '0;
        dones = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W + 8; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL reset_mid_no_done: got %0d cycles with done/busy, want 0", dones);
        end
        run_op(4'd2, 32'd1, 32'd1, 1'b0, lat, bcnt);
        total++;
        if (result !== 32'd2 || done !== 1'b1 || lat !== 1 || {hi, lo} !== {m_hi, m_lo}) begin
            bad++;
            $display("FAIL reset_mid_add: got res=%h done=%b lat=%0d hi=%h lo=%h, want res=2 done=1 lat=1 hi=0 lo=0",
                     result, done, lat, hi, lo);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; OP = '0; In1 = '0; In2 = '0;
        test_reset;
        test_vectors;
        test_random;
        test_busy_ignore;
        test_back_to_back;
        test_div_zero;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
